// File: rtl/posit_unpacker.sv
// Posit decoder: splits a BITS-wide posit into sign, signed regime (seed),
// exponent and MSB-aligned fraction. The regime run is scanned one bit per cycle.
module posit_unpacker #(
    parameter int BITS = 32,
    parameter int ES   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] in_posit,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sign,
    output logic [BITS-1:0] out_seed,
    output logic [ES-1:0]   out_exp,
    output logic [BITS-1:0] out_frac,
    output logic            out_zero,
    output logic            out_nar
);
    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SCAN    = 2'd1;
    localparam logic [1:0] EXTRACT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]      state_reg;
    logic [BITS-2:0] sr_reg;
    logic            r0_reg;
    logic [CW-1:0]   cnt_reg;
    logic            sign_reg;
    logic [BITS-1:0] seed_reg;
    logic [ES-1:0]   exp_reg;
    logic [BITS-1:0] frac_reg;
    logic            zero_reg;
    logic            nar_reg;

    logic [BITS-2:0] body;
    logic            is_zero;
    logic            is_nar;
    logic [BITS-2:0] sr_shift;
    logic [CW-1:0]   cnt_inc;
    logic            scan_stop;
    logic [BITS-2:0] rem;
    logic [BITS-1:0] run_len;
    logic [BITS-1:0] seed_next;

    // Low bits of the two's complement equal the two's complement of the low bits.
    assign body     = in_posit[BITS-1] ? (~in_posit[BITS-2:0] + 1'b1) : in_posit[BITS-2:0];
    assign is_zero  = (in_posit == '0);
    assign is_nar   = (in_posit == {1'b1, {(BITS-1){1'b0}}});
    assign sr_shift = {sr_reg[BITS-3:0], 1'b0};
    assign cnt_inc  = cnt_reg + 1'b1;

    // Every SCAN cycle consumes one run bit; looking at the bit that becomes the
    // MSB after this shift lets the run end without an extra idle check cycle.
    assign scan_stop = (sr_shift[BITS-2] != r0_reg) || (cnt_inc == LAST);

    // In EXTRACT the MSB is the terminating bit unless the run filled the word.
    assign rem       = (cnt_reg == LAST) ? sr_reg : sr_shift;
    assign run_len   = {{(BITS-CW){1'b0}}, cnt_reg};
    assign seed_next = r0_reg ? (run_len - 1'b1) : (~run_len + 1'b1);

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign out_sign  = sign_reg;
    assign out_seed  = seed_reg;
    assign out_exp   = exp_reg;
    assign out_frac  = frac_reg;
    assign out_zero  = zero_reg;
    assign out_nar   = nar_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            r0_reg    <= 1'b0;
            cnt_reg   <= '0;
            sign_reg  <= 1'b0;
            seed_reg  <= '0;
            exp_reg   <= '0;
            frac_reg  <= '0;
            zero_reg  <= 1'b0;
            nar_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg <= in_posit[BITS-1];
                        sr_reg   <= body;
                        r0_reg   <= body[BITS-2];
                        cnt_reg  <= '0;
                        zero_reg <= is_zero;
                        nar_reg  <= is_nar;
                        seed_reg <= '0;
                        exp_reg  <= '0;
                        frac_reg <= '0;
                        state_reg <= (is_zero || is_nar) ? DONE : SCAN;
                    end
                end
                SCAN: begin
                    sr_reg  <= sr_shift;
                    cnt_reg <= cnt_inc;
                    if (scan_stop) begin
                        state_reg <= EXTRACT;
                    end
                end
                EXTRACT: begin
                    seed_reg  <= seed_next;
                    exp_reg   <= rem[BITS-2 -: ES];
                    frac_reg  <= {rem[BITS-2-ES:0], {(ES+1){1'b0}}};
                    state_reg <= DONE;
                end
                default: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/posit_unpacker.md
POSIT_UNPACKER -- requirements
Module: posit_unpacker

Interface
REQ-001 SHALL have parameter BITS, default 32, posit word width (>= 4).
REQ-002 SHALL have parameter ES, default 3, exponent field width (1 <= ES <= BITS-3).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  posit word on in_posit is valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port in_posit  input  BITS  encoded posit.
REQ-008 SHALL have port out_valid  output  1  decoded fields valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the decoded fields.
REQ-010 SHALL have port out_sign  output  1  sign bit of the posit.
REQ-011 SHALL have port out_seed  output  BITS  signed regime value (two's complement), same format as the packer seed input.
REQ-012 SHALL have port out_exp  output  ES  exponent field, MSB first.
REQ-013 SHALL have port out_frac  output  BITS  fraction bits, MSB-aligned, zero-filled, hidden bit excluded.
REQ-014 SHALL have port out_zero  output  1  input was all zeros.
REQ-015 SHALL have port out_nar  output  1  input was 1 followed by BITS-1 zeros (NaR).

Function
REQ-016 SHALL implement states IDLE, SCAN, EXTRACT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 A word SHALL be accepted on a rising edge where in_valid & in_ready.
REQ-019 On accept, the block SHALL latch sign = in_posit[BITS-1] and body = low BITS-1 bits of (sign ? two's complement of in_posit : in_posit).
REQ-020 On accept, the block SHALL record r0 = body MSB and clear the run counter cnt.
REQ-021 On accept of zero or NaR, the block SHALL go directly to DONE.
REQ-021a For zero or NaR, the block SHALL drive seed, exp and frac as 0.
REQ-021b For zero or NaR, the block SHALL set out_zero or out_nar respectively.
REQ-022 On any other accepted word, the block SHALL go to SCAN.
REQ-023 In SCAN, while the shift-register MSB equals r0 and cnt < BITS-1, the block SHALL shift the register left by 1 with zero fill and increment cnt, one bit per cycle.
REQ-024 In SCAN, otherwise, the block SHALL go to EXTRACT; the run length is m = cnt.
REQ-025 In EXTRACT, the block SHALL discard the terminating bit (absent when m = BITS-1).
REQ-025a In EXTRACT, the block SHALL take the next ES bits as out_exp; bits beyond the word read as 0.
REQ-025b In EXTRACT, the block SHALL place the remaining bits MSB-aligned into out_frac.
REQ-025c In EXTRACT, the block SHALL set out_seed = r0 ? m-1 : -m.
REQ-025d EXTRACT SHALL then go to DONE.
REQ-026 Latency SHALL be 1 cycle from accept edge to out_valid for zero/NaR, and m+2 cycles for all other inputs.
REQ-027 In DONE, all out_* SHALL hold stable while out_ready = 0.
REQ-027a In DONE, on an edge with out_ready = 1, the block SHALL return to IDLE and clear out_valid.
REQ-028 No new word SHALL be accepted in the same cycle as the DONE handoff; the next accept is at the earliest one cycle later.
REQ-029 in_posit changes after the accept edge SHALL have no effect on the current decode.
REQ-030 Decoded fields SHALL satisfy: feeding out_frac, out_exp and out_seed to the packer with sign 0 SHALL reproduce body with a 0 sign bit.

Reset
REQ-031 While rst = 1 at a rising edge, the block SHALL enter IDLE from any state, including mid-SCAN or DONE.
REQ-032 Reset values SHALL be: out_valid = 0, in_ready = 1 after reset release, and all out_* data and flags = 0.
REQ-033 Reset SHALL discard any in-flight word; no output SHALL be produced for it.

Verification (BITS=8, ES=1 unless stated)
REQ-034 in_posit 0x00 -> out_zero = 1, seed/exp/frac = 0, out_valid 1 cycle after accept; 0x80 -> out_nar = 1.
REQ-035 0x40 -> sign 0, seed 0, exp 0, frac 0x00, latency 3.
REQ-035a 0x6C -> seed 1, exp 1, frac 0x80, latency 4.
REQ-036 0xC0 -> sign 1, seed 0, exp 0, frac 0x00.
REQ-036a 0x01 -> seed -6 (0xFA), exp 0, frac 0, latency 8.
REQ-036b 0x7F -> seed 6, latency 9, no terminating bit.
REQ-037 Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready = 0, in_valid ignored; release -> IDLE next cycle.
REQ-038 Assert rst during SCAN of 0x01 -> IDLE next cycle, out_valid never rises; a following 0x40 decodes correctly.
REQ-039 Default parameters (32/3): random posits round-trip through packer -> unpacker with fields identical to packer inputs.
